// File: rtl/fetch_sequencer.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : fetch_sequencer
// Brief    : Program-ROM fetch/issue sequencer with run, step and halt control.
//            Optional build macro FETCH_SEQ_LOOP_EN: wrap pc past the last word
//            and keep fetching instead of halting at end-of-program.
// Revision : 1.0
//------------------------------------------------------------------------------
module fetch_sequencer #(
  parameter int ADDR_W = 3,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              step,
  input  logic              halt_req,
  input  logic              jump_valid,
  input  logic [ADDR_W-1:0] jump_addr,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_data,
  output logic [DATA_W-1:0] ir,
  output logic              ir_valid,
  input  logic              ir_ready,
  output logic [ADDR_W-1:0] pc,
  output logic              halted
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_ISSUE = 2'd2;
  localparam logic [1:0] S_HALT  = 2'd3;

`ifndef FETCH_SEQ_LOOP_EN
  localparam logic [ADDR_W-1:0] PC_LAST = '1;
`endif

  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [DATA_W-1:0] ir_q, ir_d;
  logic              ir_valid_q, ir_valid_d;
  logic              halt_pend_q, halt_pend_d;
  logic              step_mode_q, step_mode_d;
  logic              handshake;
  logic              eop;

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    ir_d        = ir_q;
    ir_valid_d  = ir_valid_q;
    halt_pend_d = halt_pend_q;
    step_mode_d = step_mode_q;
    handshake   = (state_q == S_ISSUE) && ir_valid_q && ir_ready;
`ifdef FETCH_SEQ_LOOP_EN
    eop         = 1'b0;
`else
    eop         = handshake && !jump_valid && (pc_q == PC_LAST);
`endif

    // A halt request seen while busy waits for the next issue boundary.
    if ((state_q == S_FETCH || state_q == S_ISSUE) && halt_req) begin
      halt_pend_d = 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        if (halt_req) begin
          state_d = S_HALT;
        end else if (start) begin
          state_d     = S_FETCH;
          step_mode_d = 1'b0;
        end else if (step) begin
          state_d     = S_FETCH;
          step_mode_d = 1'b1;
        end
      end
      S_FETCH: begin
        ir_d       = rom_data;
        ir_valid_d = 1'b1;
        state_d    = S_ISSUE;
      end
      S_ISSUE: begin
        if (handshake) begin
          ir_valid_d = 1'b0;
          pc_d       = jump_valid ? jump_addr : pc_q + ADDR_W'(1);
          if (halt_pend_q || halt_req) begin
            state_d = S_HALT;
          end else if (step_mode_q) begin
            state_d = S_IDLE;
          end else if (eop) begin
            state_d = S_HALT;
          end else begin
            state_d = S_FETCH;
          end
        end
      end
      S_HALT: begin
        if (start) begin
          state_d     = S_FETCH;
          step_mode_d = 1'b0;
        end else if (step) begin
          state_d     = S_FETCH;
          step_mode_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (state_d == S_HALT && state_q != S_HALT) begin
      halt_pend_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      pc_q        <= '0;
      ir_q        <= '0;
      ir_valid_q  <= 1'b0;
      halt_pend_q <= 1'b0;
      step_mode_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      ir_q        <= ir_d;
      ir_valid_q  <= ir_valid_d;
      halt_pend_q <= halt_pend_d;
      step_mode_q <= step_mode_d;
    end
  end

  assign rom_addr = pc_q;
  assign pc       = pc_q;
  assign ir       = ir_q;
  assign ir_valid = ir_valid_q;
  assign halted   = (state_q == S_HALT);

endmodule
`default_nettype wire
